// File: rtl/axi_full_burst_master.sv
// AXI4-full self-test initiator: writes NUM_BURSTS INCR bursts of a counting pattern, then reads them back and compares.
// One transaction outstanding at a time; each channel waits on its partner's READY/VALID, with no bubble between beats.
module axi_full_burst_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_BASE = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [7:0]                        err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [7:0]    LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [7:0]    LAST_BURST  = 8'(NUM_BURSTS - 1);
    localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_LEN * (DW / 8));

    typedef enum logic [2:0] {
        S_IDLE, S_W_ADDR, S_W_DATA, S_W_RESP, S_R_ADDR, S_R_DATA, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    burst, beat;
    logic [AW-1:0] burst_addr;
    logic [DW-1:0] pattern;
    logic          beat_last, burst_last;

    // Address wraps modulo 2^AW; the pattern is the 1-based global beat number.
    assign burst_addr = TARGET_BASE + AW'(burst) * BURST_BYTES;
    assign pattern    = DW'(burst) * DW'(BURST_LEN) + DW'(beat) + DW'(1);
    assign beat_last  = (beat == LAST_BEAT);
    assign burst_last = (burst == LAST_BURST);

    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_WSTRB   = '1;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_AWADDR  = '0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_ARADDR  = '0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_W_ADDR;
            S_W_ADDR: begin
                M_AXI_AWVALID = 1'b1;
                M_AXI_AWADDR  = burst_addr;
                if (M_AXI_AWREADY) state_nxt = S_W_DATA;
            end
            S_W_DATA: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WDATA  = pattern;
                M_AXI_WLAST  = beat_last;
                if (M_AXI_WREADY && beat_last) state_nxt = S_W_RESP;
            end
            S_W_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_nxt = burst_last ? S_R_ADDR : S_W_ADDR;
            end
            S_R_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                M_AXI_ARADDR  = burst_addr;
                if (M_AXI_ARREADY) state_nxt = S_R_DATA;
            end
            S_R_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && beat_last) state_nxt = burst_last ? S_DONE : S_R_ADDR;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            burst     <= '0;
            beat      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    burst     <= '0;
                    beat      <= '0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    err_count <= '0;
                end
                S_W_DATA: if (M_AXI_WREADY) beat <= beat_last ? 8'd0 : beat + 8'd1;
                S_W_RESP: if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) error <= 1'b1;
                    burst <= burst_last ? 8'd0 : burst + 8'd1;
                end
                // The burst always ends on the internal beat count; a wrong RLAST only flags an error.
                S_R_DATA: if (M_AXI_RVALID) begin
                    if (M_AXI_RDATA != pattern) begin
                        error <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                    if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != beat_last) error <= 1'b1;
                    beat <= beat_last ? 8'd0 : beat + 8'd1;
                    if (beat_last) burst <= burst_last ? 8'd0 : burst + 8'd1;
                end
                S_DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/axi_full_burst_master.md
Name: axi_full_burst_master

Overview:
- AXI4-full initiator: on a start pulse, writes NUM_BURSTS incrementing-data INCR bursts to a target slave, reads them back and compares.
- Reports pass/fail, error count and response errors.
- Acts as the hardware counterpart of the bench master agent: drives the team's AXI-full slave (or any AXI4 memory) in system-level self-test.
- One outstanding transaction at a time; no ID, user or QoS usage.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width (32 or 64)
BURST_LEN, 8, beats per burst (1..256); AxLEN = BURST_LEN-1
NUM_BURSTS, 4, bursts per pass (1..256)
TARGET_BASE, 0, byte address of first burst, aligned to burst size

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  synchronous active-low reset
start  in  1  single-cycle pulse, begins a pass; ignored while busy=1
busy  out  1  high from cycle after accepted start until done
done  out  1  set when pass completes; cleared on next accepted start
error  out  1  sticky: any data mismatch or non-OKAY BRESP/RRESP; cleared on accepted start
err_count  out  8  number of mismatching read beats, saturates at 255
M_AXI_AWADDR / M_AXI_ARADDR  out  ADDR_WIDTH each  burst start address
M_AXI_AWLEN / M_AXI_ARLEN  out  8 each  constant BURST_LEN-1
M_AXI_AWSIZE / M_AXI_ARSIZE  out  3 each  constant clog2(DATA_WIDTH/8)
M_AXI_AWBURST / M_AXI_ARBURST  out  2 each  constant 2'b01 (INCR)
M_AXI_AWVALID, M_AXI_AWREADY  out, in  1 each  write-address handshake
M_AXI_WDATA  out  DATA_WIDTH  write data
M_AXI_WSTRB  out  DATA_WIDTH/8  constant all-ones
M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY  out, out, in  1 each  write-data channel
M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY  in 2, in 1, out 1  write response
M_AXI_ARVALID, M_AXI_ARREADY  out, in  1 each  read-address handshake
M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY  in DATA_WIDTH, in 2, in 1, in 1, out 1  read channel

Behaviour:
- Reset (ARESETN=0 at edge): state IDLE; all VALID/READY outputs 0, busy/done/error 0, err_count 0, burst and beat counters 0. Reset mid-burst abandons the transaction immediately with no completion of the pending beats.
- FSM: IDLE -> W_ADDR -> W_DATA -> W_RESP -> (next burst W_ADDR | R_ADDR) -> R_DATA -> (next burst R_ADDR | DONE) -> IDLE.
- IDLE: start=1 -> W_ADDR next cycle. AWVALID=1 in the first W_ADDR cycle; busy=1, done=0, error=0, err_count=0.
- Address of burst b = TARGET_BASE + b*BURST_LEN*(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH.
- W_ADDR: AWVALID held with AWADDR stable until AWREADY; the handshake cycle moves to W_DATA.
- W_DATA: WVALID=1 from the first cycle. Beat k of burst b carries WDATA = b*BURST_LEN+k+1, zero-extended. WDATA and WLAST are held stable while WREADY=0. WLAST=1 only on beat BURST_LEN-1 (every beat when BURST_LEN=1). The handshake on the last beat moves to W_RESP.
- W_RESP: BREADY=1. On BVALID, BRESP!=OKAY sets error. Next state is W_ADDR for b+1, or R_ADDR with b reset to 0 after the last burst.
- R_ADDR: same rules as W_ADDR on the AR channel.
- R_DATA: RREADY=1. Each RVALID beat k is compared with b*BURST_LEN+k+1. On mismatch, err_count increments (saturating at 255) and error=1. RRESP!=OKAY sets error.
- Read beat counting: RLAST is checked against the internal beat count. Early or missing RLAST sets error, and the burst ends on the internal count.
- Completion: after the last read burst, DONE for one cycle, then IDLE with done=1 and busy=0.
- start asserted while busy has no effect.
- Throughput: no bubble required between beats while READY stays high.

Test Plan:
- Default params, always-ready memory slave: start -> 4 write bursts with WDATA 1..32, then 4 reads at 0x00/0x20/0x40/0x60; done=1, error=0, err_count=0.
- Slave corrupts read beat 3 of burst 1 (returns 0 instead of 12) -> err_count=1, error=1, done=1.
- Random READY backpressure on AW/W/AR (including WREADY low on the WLAST beat) -> AWADDR/WDATA/WLAST stay stable while stalled; final result pass.
- BRESP=SLVERR on burst 2 -> error=1, err_count=0, pass still completes all reads.
- ARESETN low for 1 cycle mid-W_DATA -> all outputs 0 next cycle. A new start then completes a clean pass.
- BURST_LEN=1, NUM_BURSTS=1 -> WLAST on the single beat with WDATA=1; pulsing start while busy -> no restart, done asserted exactly once.
